uart_tx_drain: RTL

//   Downstream consumer of the 8-bit sample FIFO. It pops one byte at a time whenever the

---
 rtl/cold_storage_pkg.sv | 26 ++
 rtl/uart_baud_counter.sv | 44 ++++
 rtl/uart_tx_drain.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cold_storage_pkg.sv
// Shared definitions for the cold-storage controller.
// FSM encodings, UART defaults and line levels.
package cold_storage_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    localparam int   DEF_CLKS_PER_BIT = 104;
    localparam logic UART_IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        LOAD   = ST_LOAD,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter for the UART drain.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clk_1MHz,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the end of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Drains the sample FIFO one byte at a time onto the
// telemetry UART line: start, data LSB-first, opt. parity, stop.
module uart_tx_drain
    import cold_storage_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk_1MHz,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int            IW       = $clog2(DATA_WIDTH) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [IW-1:0]         idx_q;
    logic [IW-1:0]         idx_d;
    logic                  par_q;
    logic                  par_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  bit_end;
    logic                  cnt_clr;
    logic                  cnt_en;

    assign cnt_clr = (state_q == LOAD);
    assign cnt_en  = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_1MHz (clk_1MHz),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .bit_end_o(bit_end)
    );

    // Frame sequencing, byte capture and shifting.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_data;
                par_d   = ^fifo_data;
                idx_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, so tx is a clean register.
    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    // State, datapath and line registers.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= UART_IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign tx         = tx_q;
    assign fifo_rd_en = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && bit_end;

endmodule
